// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

  localparam int IMEM_XLEN = 32;
  localparam logic [IMEM_XLEN-1:0] IMEM_ERR_DATA = 32'h0000_0000;

  typedef struct packed {
    logic [IMEM_XLEN-1:0] data;
    logic                 err;
  } imem_resp_t;

  // Misaligned or beyond the last word of a depth-word array.
  function automatic logic addr_err(input logic [IMEM_XLEN-1:0] addr, input int depth);
    logic [IMEM_XLEN-1:0] limit;
    limit = IMEM_XLEN'(depth) << 2;
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/imem_resp_buf.sv
// Circular response FIFO; push and pop may coincide at any occupancy, clear empties it.
module imem_resp_buf
  import imem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  imem_resp_t    push_data,
  input  logic          pop,
  output imem_resp_t    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  imem_resp_t    entries_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          push_s, pop_s;

  // Effective handshakes, wrapped pointers and next occupancy.
  always_comb begin
    full         = (count_r == CW'(DEPTH));
    empty        = (count_r == {CW{1'b0}});
    pop_s        = pop && !empty;
    push_s       = push && (!full || pop_s);
    wr_ptr_nxt_s = (wr_ptr_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
    rd_ptr_nxt_s = (rd_ptr_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_nxt_s = count_r;
    end
    head  = entries_r[rd_ptr_r];
    count = count_r;
  end

  // Storage and pointer state; reset also zeroes storage so the head reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= {$bits(imem_resp_t){1'b0}};
      end
    end else if (clear) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        entries_r[wr_ptr_r] <= push_data;
        wr_ptr_r            <= wr_ptr_nxt_s;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_nxt_s;
      end
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency array read pipeline feeding a
// credit-protected response FIFO toward the fetch stage.
module imem_responder
  import imem_pkg::*;
#(
  parameter int    XLEN        = 32,
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 2,
  parameter int    BUF_DEPTH   = 4,
  parameter string INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  // The buffer register is the last of the LATENCY stages, so only LATENCY-1 live here.
  localparam int PIPE = (LATENCY > 1) ? LATENCY - 1 : 1;

  logic [XLEN-1:0] mem_r [DEPTH_WORDS];
  logic [PIPE-1:0] pipe_valid_r;
  imem_resp_t      pipe_resp_r [PIPE];
  imem_resp_t      read_s, push_data_s, head_s;
  logic            accept_s, push_s, pop_s, credit_ok_s, buf_empty_s, buf_full_s;
  logic [IW-1:0]   inflight_s;
  logic [CW-1:0]   buf_count_s;

  // Array read; bad addresses bypass the array and return the error pattern.
  always_comb begin
    read_s.err = addr_err(req_addr, DEPTH_WORDS);
    if (read_s.err) begin
      read_s.data = IMEM_ERR_DATA;
    end else begin
      read_s.data = mem_r[req_addr[AW+1:2]];
    end
  end

  // Credit check, handshakes and buffer hookup.
  always_comb begin
    inflight_s = {IW{1'b0}};
    if (LATENCY > 1) begin
      for (int k = 0; k < PIPE; k++) begin
        inflight_s = inflight_s + IW'(pipe_valid_r[k]);
      end
    end else begin
      inflight_s = {IW{1'b0}};
    end
    credit_ok_s = !buf_full_s && ((32'(inflight_s) + 32'(buf_count_s)) < 32'(BUF_DEPTH));
    req_ready   = !rst && !flush && credit_ok_s;
    accept_s    = req_valid && req_ready;
    resp_valid  = !rst && !buf_empty_s;
    pop_s       = resp_valid && resp_ready;
    if (LATENCY > 1) begin
      push_s      = pipe_valid_r[PIPE-1];
      push_data_s = pipe_resp_r[PIPE-1];
    end else begin
      push_s      = accept_s;
      push_data_s = read_s;
    end
    resp_data = head_s.data;
    resp_err  = head_s.err;
  end

  // Valid bits advance one stage per cycle; flush or reset kills everything in flight.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pipe_valid_r <= {PIPE{1'b0}};
    end else begin
      pipe_valid_r[0] <= accept_s;
      for (int k = 1; k < PIPE; k++) begin
        pipe_valid_r[k] <= pipe_valid_r[k-1];
      end
    end
  end

  // Payload shift; qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    pipe_resp_r[0] <= read_s;
    for (int k = 1; k < PIPE; k++) begin
      pipe_resp_r[k] <= pipe_resp_r[k-1];
    end
  end

  imem_resp_buf #(.DEPTH(BUF_DEPTH)) u_resp_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (buf_count_s),
    .full      (buf_full_s),
    .empty     (buf_empty_s)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: expected words queued at accept, compared at response.
module tb_imem_responder;

  localparam int LAT = 2;
  localparam int DW  = 1024;

  logic        clk = 1'b0;
  logic        rst, req_valid, flush, resp_ready;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] req_addr, resp_data;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] exp_q [$];
  logic [32:0] e;
  logic [31:0] model_mem [DW];

  always #5 clk = ~clk;

  imem_responder #(.XLEN(32), .DEPTH_WORDS(DW), .LATENCY(LAT), .BUF_DEPTH(4), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err)
  );

  function automatic logic [32:0] model_resp(input logic [31:0] addr);
    if ((addr[1:0] != 2'b00) || (addr >= 32'h0000_1000)) return {1'b1, 32'h0000_0000};
    return {1'b0, model_mem[addr[11:2]]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0; req_addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if ({resp_err, resp_data} !== 33'h0) begin n_bad++; $display("FAIL reset_resp_out: got %h want 0", {resp_err, resp_data}); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_single(input string nm);
    @(posedge clk); #1;
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_000C;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready: got %b want 1", nm, req_ready); end
      end
      if (req_valid && req_ready) exp_q.push_back(model_resp(req_addr));
      n_cmp++;
      if (resp_valid !== 1'(k == LAT)) begin n_bad++; $display("FAIL %s_valid cyc%0d: got %b want %b", nm, k, resp_valid, (k == LAT)); end
      if (resp_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++; if ({resp_err, resp_data} !== e) begin n_bad++; $display("FAIL %s_data: got %h want %h", nm, {resp_err, resp_data}, e); end
      end
      @(posedge clk); #1 req_valid = 1'b0;
    end
  endtask

  task automatic test_stream(input string nm, input logic [31:0] addrs [$], input int want_errs);
    int first = -1, last = -1, got = 0, errs = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < addrs.size() + LAT + 3; i++) begin
      @(posedge clk); #1;
      req_valid = (i < addrs.size());
      req_addr  = (i < addrs.size()) ? addrs[i] : 32'h0;
      @(negedge clk);
      if (i < addrs.size()) begin
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready[%0d]: got %b want 1", nm, i, req_ready); end
      end
      if (req_valid && req_ready) exp_q.push_back(model_resp(req_addr));
      if (resp_valid === 1'b1) begin
        if (first < 0) first = i;
        last = i; got++;
        if (resp_err === 1'b1) errs++;
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL %s_extra: got %h want none", nm, {resp_err, resp_data}); end
        else begin
          e = exp_q.pop_front();
          if ({resp_err, resp_data} !== e) begin n_bad++; $display("FAIL %s_data[%0d]: got %h want %h", nm, got - 1, {resp_err, resp_data}, e); end
        end
      end
    end
    req_valid = 1'b0;
    n_cmp++; if (got != addrs.size()) begin n_bad++; $display("FAIL %s_count: got %0d want %0d", nm, got, addrs.size()); end
    n_cmp++; if (first != LAT) begin n_bad++; $display("FAIL %s_latency: got %0d want %0d", nm, first, LAT); end
    n_cmp++; if (last - first != addrs.size() - 1) begin n_bad++; $display("FAIL %s_gapless: got span %0d want %0d", nm, last - first, addrs.size() - 1); end
    n_cmp++; if (errs != want_errs) begin n_bad++; $display("FAIL %s_errs: got %0d want %0d", nm, errs, want_errs); end
  endtask

  task automatic test_backpressure();
    int acc = 0, got = 0;
    resp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 req_valid = 1'b1; req_addr = 32'h100 + 32'(acc) * 32'd4;
      @(negedge clk);
      if (req_ready) begin exp_q.push_back(model_resp(req_addr)); acc++; end
    end
    n_cmp++; if (acc != 4) begin n_bad++; $display("FAIL bp_accepts: got %0d want 4", acc); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b want 0", req_ready); end
    @(posedge clk); #1 req_valid = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        got++; n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_extra: got %h want none", resp_data); end
        else begin
          e = exp_q.pop_front();
          if ({resp_err, resp_data} !== e) begin n_bad++; $display("FAIL bp_data: got %h want %h", {resp_err, resp_data}, e); end
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++; if (got != 4) begin n_bad++; $display("FAIL bp_drained: got %0d want 4", got); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
  endtask

  task automatic test_flush();
    int got = 0;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 req_valid = 1'b1; req_addr = 32'h20 + 32'(i) * 32'd4;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_pre_ready[%0d]: got %b want 1", i, req_ready); end
      if (req_ready) exp_q.push_back(model_resp(req_addr));
    end
    @(posedge clk); #1 flush = 1'b1; req_addr = 32'h40;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    exp_q.delete();
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid_after: got %b want 0", resp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready_after: got %b want 1", req_ready); end
    if (req_ready) exp_q.push_back(model_resp(req_addr));
    @(posedge clk); #1 req_valid = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        got++; n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL flush_leak: got %h want none", resp_data); end
        else begin
          e = exp_q.pop_front();
          if ({resp_err, resp_data} !== e) begin n_bad++; $display("FAIL flush_data: got %h want %h", {resp_err, resp_data}, e); end
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (got != 1) begin n_bad++; $display("FAIL flush_count: got %0d want 1", got); end
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 req_valid = 1'b1; req_addr = 32'h200 + 32'(i) * 32'd4;
      @(negedge clk);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready: got %b want 0", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", resp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({resp_valid, resp_err, resp_data} !== 34'h0) begin n_bad++; $display("FAIL rstmid_outputs: got %h want 0", {resp_valid, resp_err, resp_data}); end
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0; req_valid = 1'b0;
    test_single("rstmid_first");
  endtask

  initial begin
    logic [31:0] b2b [$];
    logic [31:0] errs [$];
    for (int i = 0; i < DW; i++) model_mem[i] = $urandom;
    model_mem[3]   = 32'h0050_0093;
    model_mem[16]  = 32'h0110_0113;
    model_mem[DW-1] = 32'hDEAD_BEEF;
    for (int i = 0; i < DW; i++) dut.mem_r[i] = model_mem[i];
    for (int i = 0; i < 8; i++) b2b.push_back(32'(i) * 32'd4);
    errs = '{32'h0000_0002, 32'h0000_1000, 32'h0000_0FFC, 32'h0000_0008, 32'hFFFF_FFFC, 32'h0000_0003};

    test_reset();
    test_single("single");
    test_stream("b2b", b2b, 0);
    test_backpressure();
    test_stream("err", errs, 4);
    test_flush();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
